fetch_32: RTL and testbench
===========================

# fetch_32

Instruction fetch unit for the 32-bit core. It generates word-aligned fetch addresses and issues single-outstanding requests to the instruction memory port. Returned words are buffered in a small prefetch FIFO and presented, each with its PC, to the instruction decode stage through a valid/ready handshake. It also handles branch/jump redirects and fetch bus errors.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, 2..16

- clk_in  input  1  core clock; all state updates on rising edge
- reset_in  input  1  asynchronous, active-low reset
- mem_req_out  output  1  fetch request valid
- mem_addr_out  output  32  fetch address; held stable while mem_req_out=1 until the ack cycle
- mem_ack_in  input  1  request accepted and completed this cycle (data/err valid)
- mem_data_in  input  32  instruction word, valid when mem_ack_in=1
- mem_err_in  input  1  bus error, valid when mem_ack_in=1
- redirect_in  input  1  branch/jump redirect strobe, one cycle
- redirect_addr_in  input  32  redirect target
- inst_out  output  32  FIFO head instruction, to decode inst_in
- pc_out  output  32  PC of inst_out
- inst_valid_out  output  1  inst_out/pc_out valid
- inst_ready_in  input  1  decode accepts head this cycle
- fault_out  output  1  fetch fault pending (bus error or misaligned redirect)
- fault_addr_out  output  32  faulting address

## Operation
- States: IDLE, REQ, DROP, FAULT. Registers: fetch PC, FIFO (word + PC per entry), count, fault regs.
- Reset values: state IDLE, fetch PC = RESET_PC, mem_req_out=0, mem_addr_out=RESET_PC, inst_out=0, pc_out=0, inst_valid_out=0, fault_out=0, fault_addr_out=0, FIFO empty.
- mem_req_out=1 exactly in REQ and DROP. mem_addr_out = fetch PC in REQ, the in-flight address in DROP.
- IDLE -> REQ when count < FIFO_DEPTH (space is reserved for the single outstanding request).
- REQ with ack and no error: push {mem_data_in, mem_addr_out}; fetch PC += 4 (wraps mod 2^32). Next state is REQ if count after push < FIFO_DEPTH, else IDLE.
- REQ with ack and mem_err_in=1: no push. Go to FAULT; fault_out=1; fault_addr_out = mem_addr_out.
- Pop when inst_valid_out & inst_ready_in. Simultaneous push and pop leaves count unchanged.
- Redirect with redirect_addr_in[1:0] != 0: clear FIFO; fault_out=1; fault_addr_out = redirect_addr_in. Next state is FAULT, or DROP if a request is outstanding without ack.
- Aligned redirect: clear FIFO and set fetch PC = redirect_addr_in.
  - From IDLE or FAULT: go to REQ and clear fault_out.
  - From REQ with ack in the same cycle: returned data and err are discarded; go to REQ at the new PC.
  - From REQ without ack: go to DROP.
  - From DROP: update fetch PC and stay in DROP.
- DROP: on ack, discard data and error, then go to REQ (or FAULT if a misaligned redirect is pending).
- Redirect beats a pop in the same cycle; the popped entry counts as consumed and is not replayed.
- FAULT: no requests are issued. FIFO entries pushed before the fault still drain normally. FAULT is left only by an aligned redirect.
- inst_valid_out = (count != 0), registered. inst_out/pc_out come from the head entry and hold their values when the FIFO is empty.

## Timing
- The first rising edge after reset_in deasserts moves IDLE->REQ. mem_req_out=1 in cycle 1 with mem_addr_out=RESET_PC.
- Zero-wait memory (ack in the same cycle as the request) sustains 1 fetch/cycle while the FIFO has space.
- Ack at edge k: inst_valid_out=1 from cycle k+1 if the FIFO was empty. Fetch latency is 1 cycle beyond the memory latency.
- Redirect at edge k with no outstanding request: mem_addr_out = target from cycle k+1, and inst_valid_out=0 in cycle k+1.
- A full FIFO stops issue; the first pop re-enables REQ on the next edge.
- reset_in assertion mid-request immediately forces reset values and abandons the in-flight request.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning addr|0xA0000000, decode always ready -> mem_addr_out 0,4,8,...; inst_out 0xA0000000 with pc 0 in cycle 2, then one instruction per cycle.
- inst_ready_in=0, FIFO_DEPTH=4 -> exactly 4 acks, then mem_req_out=0; raise ready -> entries 0x0,0x4,0x8,0xC pop in order and fetch resumes at 0x10.
- 3-cycle ack latency; redirect to 0x100 one cycle after the request to 0x8 -> DROP; the 0x8 data is never presented; the next request is 0x100 and its inst is presented with pc_out=0x100.
- mem_err_in with ack on address 0x14 -> fault_out=1, fault_addr_out=0x14, no further requests; aligned redirect to 0x40 -> fault_out=0 and fetch resumes at 0x40.
- Redirect to 0x102 -> FIFO empty, fault_out=1, fault_addr_out=0x102, mem_req_out=0.
- reset_in pulsed low while the FIFO holds 2 entries and a request is pending -> all outputs at reset values immediately; refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_32.sv
// Instruction fetch unit: single-outstanding word fetches into a prefetch FIFO,
// presented with their PCs to decode; handles redirects and fetch bus errors.
//
// state | meaning
// IDLE  | waiting for FIFO space before issuing the next fetch
// REQ   | fetch at the fetch PC outstanding on the memory port
// DROP  | stale request in flight after a redirect; its response is discarded
// FAULT | bus error or misaligned redirect; no fetches until an aligned redirect
module fetch_32 #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_data_in,
  input  logic        mem_err_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_addr_in,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic        fault_out,
  output logic [31:0] fault_addr_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_q, inst_d, pc_out_q, pc_out_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;
  logic [31:0]   buf_inst_q [FIFO_DEPTH];
  logic [31:0]   buf_pc_q   [FIFO_DEPTH];
  logic          ack, pop, push, clear, redir_mis, outstanding;

  assign mem_req_out  = (state_q == S_REQ) || (state_q == S_DROP);
  assign mem_addr_out = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign ack          = mem_req_out & mem_ack_in;
  assign outstanding  = mem_req_out & ~mem_ack_in;
  assign pop          = valid_q & inst_ready_in;
  assign redir_mis    = redirect_in & (redirect_addr_in[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    push         = 1'b0;
    clear        = 1'b0;

    case (state_q)
      S_IDLE: if (count_q < DEPTH_C) state_d = S_REQ;
      S_REQ: begin
        if (ack) begin
          if (mem_err_in) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = mem_addr_out;
          end else begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
      end
      S_DROP: if (ack) state_d = fault_q ? S_FAULT : S_REQ;
      default: ;
    endcase

    // A redirect overrides whatever the memory returned this cycle.
    if (redirect_in) begin
      clear = 1'b1;
      push  = 1'b0;
      if (outstanding && (state_q == S_REQ)) drop_addr_d = pc_q;
      if (redir_mis) begin
        pc_d         = pc_q;
        fault_d      = 1'b1;
        fault_addr_d = redirect_addr_in;
        state_d      = outstanding ? S_DROP : S_FAULT;
      end else begin
        pc_d    = redirect_addr_in;
        fault_d = 1'b0;
        state_d = outstanding ? S_DROP : S_REQ;
      end
    end

    if (clear) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end

    if (push && (count_d >= DEPTH_C)) state_d = S_IDLE;

    // Head outputs are registered; an entry written this cycle may become the head.
    valid_d  = (count_d != '0);
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    if (valid_d) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        inst_d   = mem_data_in;
        pc_out_d = mem_addr_out;
      end else begin
        inst_d   = buf_inst_q[rd_ptr_d];
        pc_out_d = buf_pc_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inst_q       <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      buf_inst_q[wr_ptr_q] <= mem_data_in;
      buf_pc_q[wr_ptr_q]   <= mem_addr_out;
    end
  end

  assign inst_out       = inst_q;
  assign pc_out         = pc_out_q;
  assign inst_valid_out = valid_q;
  assign fault_out      = fault_q;
  assign fault_addr_out = fault_addr_q;

endmodule

// File: tb/tb_fetch_32.sv
// Bench for fetch_32: address-derived memory model with programmable latency,
// directed stimulus and an in-order scoreboard on the decode handshake.
module tb_fetch_32;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;
  logic        mem_err_in;
  logic        redirect_in;
  logic [31:0] redirect_addr_in;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid_out;
  logic        inst_ready_in;
  logic        fault_out;
  logic [31:0] fault_addr_out;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int ack_cnt = 0;
  int lat     = 0;
  int wcnt    = 0;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [63:0] exp_q[$];

  fetch_32 #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in), .mem_err_in(mem_err_in),
    .redirect_in(redirect_in), .redirect_addr_in(redirect_addr_in),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid_out(inst_valid_out),
    .inst_ready_in(inst_ready_in), .fault_out(fault_out), .fault_addr_out(fault_addr_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory model: word = address | 0xA0000000, ack after 'lat' wait cycles.
  assign mem_ack_in  = mem_req_out && (wcnt >= lat);
  assign mem_data_in = mem_addr_out | 32'hA000_0000;
  assign mem_err_in  = err_en && (mem_addr_out == err_addr);

  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) wcnt <= 0;
    else if (mem_req_out && !mem_ack_in) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk_in) if (reset_in && mem_req_out && mem_ack_in) ack_cnt <= ack_cnt + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [31:0] pc);
    exp_q.push_back({pc | 32'hA000_0000, pc});
  endfunction

  // Scoreboard monitor: every accepted instruction must match the next expected one.
  always @(negedge clk_in) begin
    if (reset_in && inst_valid_out && inst_ready_in) begin
      logic [63:0] e;
      acc_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_inst: got pc %h inst %h, expected none", pc_out, inst_out);
      end else begin
        e = exp_q.pop_front();
        chk32("sb_inst", inst_out, e[63:32]);
        chk32("sb_pc", pc_out, e[31:0]);
      end
    end
  end

  task automatic do_redirect(input logic [31:0] a);
    @(posedge clk_in); #1;
    redirect_in      = 1'b1;
    redirect_addr_in = a;
    @(posedge clk_in); #1;
    redirect_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic wait_req_addr(input string name, input logic [31:0] a);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (mem_req_out && mem_addr_out == a) break;
    end
    chk1({name, "_req"}, mem_req_out, 1'b1);
    chk32({name, "_addr"}, mem_addr_out, a);
  endtask

  task automatic wait_acc(input string name, input int n);
    inst_ready_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_in); #1;
      if (acc_cnt >= n) break;
    end
    inst_ready_in = 1'b0;
    chk32(name, 32'(acc_cnt), 32'(n));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_req"}, mem_req_out, 1'b0);
    chk32({tag, "_addr"}, mem_addr_out, 32'h0);
    chk1({tag, "_valid"}, inst_valid_out, 1'b0);
    chk32({tag, "_inst"}, inst_out, 32'h0);
    chk32({tag, "_pc"}, pc_out, 32'h0);
    chk1({tag, "_fault"}, fault_out, 1'b0);
    chk32({tag, "_faddr"}, fault_addr_out, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in         = 1'b0;
    inst_ready_in    = 1'b0;
    redirect_in      = 1'b0;
    redirect_addr_in = 32'h0;
    repeat (2) @(negedge clk_in);
    chk_reset_vals("rst");

    // Fill from reset with decode stalled: exactly four fetches, then stop.
    reset_in = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk_in);
      if (n <= 4) begin
        chk1("fill_req", mem_req_out, 1'b1);
        chk32("fill_addr", mem_addr_out, 32'(4 * (n - 1)));
      end else begin
        chk1("full_noreq", mem_req_out, 1'b0);
      end
      if (n == 2) begin
        chk1("c2_valid", inst_valid_out, 1'b1);
        chk32("c2_inst", inst_out, 32'hA000_0000);
        chk32("c2_pc", pc_out, 32'h0);
      end
    end
    chk32("fill_acks", 32'(ack_cnt), 32'd4);

    // Drain in order and stream at one per cycle.
    for (int i = 0; i < 7; i++) push_exp(32'(4 * i));
    inst_ready_in = 1'b1;
    wait_req_addr("resume", 32'h10);
    wait_acc("acc_stream", 7);
    repeat (6) @(negedge clk_in);

    // Bus error on 0x14: earlier entries still drain, fetching stops.
    err_en   = 1'b1;
    err_addr = 32'h14;
    for (int i = 0; i < 5; i++) push_exp(32'(4 * i));
    do_redirect(32'h0);
    chk1("redir0_valid", inst_valid_out, 1'b0);
    chk32("redir0_addr", mem_addr_out, 32'h0);
    wait_acc("acc_err", 12);
    chk1("err_fault", fault_out, 1'b1);
    chk32("err_faddr", fault_addr_out, 32'h14);
    begin
      int a0;
      a0 = ack_cnt;
      repeat (4) @(negedge clk_in);
      chk1("fault_noreq", mem_req_out, 1'b0);
      chk32("fault_noack", 32'(ack_cnt), 32'(a0));
    end
    err_en = 1'b0;

    // Aligned redirect leaves FAULT.
    for (int i = 0; i < 4; i++) push_exp(32'h40 + 32'(4 * i));
    do_redirect(32'h40);
    chk1("r40_fault", fault_out, 1'b0);
    chk1("r40_req", mem_req_out, 1'b1);
    chk32("r40_addr", mem_addr_out, 32'h40);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (!mem_req_out) break;
    end
    chk1("r40_full", mem_req_out, 1'b0);
    wait_acc("acc_r40", 16);

    // Misaligned redirect.
    do_redirect(32'h102);
    chk1("mis_valid", inst_valid_out, 1'b0);
    chk1("mis_fault", fault_out, 1'b1);
    chk32("mis_faddr", fault_addr_out, 32'h102);
    chk1("mis_req", mem_req_out, 1'b0);
    repeat (3) @(negedge clk_in);
    chk1("mis_req_hold", mem_req_out, 1'b0);

    // Redirect while a slow request is in flight: its data is dropped.
    lat = 3;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h100);
    inst_ready_in = 1'b1;
    do_redirect(32'h0);
    chk1("slow_req", mem_req_out, 1'b1);
    chk32("slow_addr", mem_addr_out, 32'h0);
    chk1("slow_fault", fault_out, 1'b0);
    wait_req_addr("req8", 32'h8);
    @(posedge clk_in); #1;
    redirect_in      = 1'b1;
    redirect_addr_in = 32'h100;
    @(posedge clk_in); #1;
    redirect_in = 1'b0;
    @(negedge clk_in);
    chk1("drop_req", mem_req_out, 1'b1);
    chk32("drop_addr", mem_addr_out, 32'h8);
    wait_req_addr("req100", 32'h100);
    wait_acc("acc_drop", 19);

    // Reset mid-request with two entries buffered.
    do_redirect(32'h300);
    wait_req_addr("req308", 32'h308);
    chk1("pre_rst_valid", inst_valid_out, 1'b1);
    chk32("pre_rst_pc", pc_out, 32'h300);
    #2;
    reset_in = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    lat = 0;
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk1("refetch_req", mem_req_out, 1'b1);
    chk32("refetch_addr", mem_addr_out, 32'h0);
    push_exp(32'h0);
    push_exp(32'h4);
    wait_acc("acc_refetch", 21);

    repeat (5) @(negedge clk_in);
    chk32("sb_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
